// File: rtl/rob_retire_queue.sv
// Reorder buffer: in-order dispatch, CDB capture, speculative operand lookup, in-order retire with store handshake and mispredict flush.
// Lookup/retire outputs are combinational, state updates land next edge; rob_full holds the dispatcher, a head store stalls until retire_store_executed.
module rob_retire_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dispatch_en,
  input  logic [5:0]  dispatch_rd_tag,
  input  logic [4:0]  dispatch_rd_reg,
  input  logic [31:0] dispatch_pc,
  input  logic [1:0]  dispatch_instr_type,
  output logic        rob_full,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_result,
  input  logic        cdb_branch,
  input  logic        cdb_branch_taken,
  input  logic        rs1_reg_ren,
  input  logic [5:0]  rs1_token,
  output logic [31:0] rs1_data_spec,
  output logic        rs1_data_valid,
  input  logic        rs2_reg_ren,
  input  logic [5:0]  rs2_token,
  output logic [31:0] rs2_data_spec,
  output logic        rs2_data_valid,
  output logic [5:0]  retire_rd_tag,
  output logic [4:0]  retire_rd_reg,
  output logic [31:0] retire_data,
  output logic [31:0] retire_pc,
  output logic        retire_branch,
  output logic        retire_branch_taken,
  output logic        retire_store_ready,
  output logic        retire_valid,
  output logic        retire_spec_valid,
  output logic        retire_flush,
  input  logic        retire_store_executed
);

  localparam logic [1:0]     T_NONE   = 2'd0;
  localparam logic [1:0]     T_BRANCH = 2'd1;
  localparam logic [1:0]     T_STORE  = 2'd2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic        vld;
    logic        spec_vld;
    logic        taken;
    logic [1:0]  itype;
    logic [5:0]  rd_tag;
    logic [4:0]  rd_reg;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  entry_t           head_ent;
  logic             push, pop;
  logic [1:0]       push_type;

  logic        rs_ren [2];
  logic [5:0]  rs_tok [2];
  logic [31:0] rs_dat [2];
  logic        rs_vld [2];

  assign head_ent  = ent_q[head_q];
  assign push_type = (dispatch_instr_type == 2'd3) ? T_NONE : dispatch_instr_type;

  assign rob_full            = (cnt_q == FULL_CNT);
  assign retire_valid        = head_ent.vld;
  assign retire_spec_valid   = head_ent.vld & head_ent.spec_vld;
  assign retire_store_ready  = retire_spec_valid & (head_ent.itype == T_STORE);
  assign retire_branch       = retire_valid & (head_ent.itype == T_BRANCH);
  assign retire_branch_taken = retire_valid & head_ent.taken;
  assign retire_rd_tag       = retire_valid ? head_ent.rd_tag : 6'd0;
  assign retire_rd_reg       = retire_valid ? head_ent.rd_reg : 5'd0;
  assign retire_pc           = retire_valid ? head_ent.pc     : 32'd0;
  assign retire_data         = retire_valid ? head_ent.data   : 32'd0;

  assign pop          = retire_spec_valid & ((head_ent.itype != T_STORE) | retire_store_executed);
  assign retire_flush = pop & (head_ent.itype == T_BRANCH) & head_ent.taken;
  // Full is judged on registered count, so a same-cycle retire never frees a slot for this push.
  assign push         = dispatch_en & ~rob_full & ~retire_flush;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      ent_d[head_q].vld = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      ent_d[tail_q] = '{vld: 1'b1, spec_vld: 1'b0, taken: 1'b0, itype: push_type,
                        rd_tag: dispatch_rd_tag, rd_reg: dispatch_rd_reg,
                        pc: dispatch_pc, data: 32'd0};
      tail_d = tail_q + PTR_W'(1);
    end
    // Capture runs after the push so a result for the entry being dispatched is not lost.
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_d[i].vld && ent_d[i].rd_tag == cdb_tag) begin
          ent_d[i].data     = cdb_result;
          ent_d[i].spec_vld = 1'b1;
          ent_d[i].taken    = cdb_branch & cdb_branch_taken;
        end
      end
    end
    cnt_d = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    if (retire_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rs_ren[0] = rs1_reg_ren;
  assign rs_ren[1] = rs2_reg_ren;
  assign rs_tok[0] = rs1_token;
  assign rs_tok[1] = rs2_token;

  // CDB forwarding beats the stored copy so a consumer sees a result the cycle it is broadcast.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_dat[p] = 32'd0;
      rs_vld[p] = 1'b0;
      if (rs_ren[p]) begin
        if (cdb_valid && cdb_tag == rs_tok[p]) begin
          rs_dat[p] = cdb_result;
          rs_vld[p] = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].vld && ent_q[i].spec_vld && ent_q[i].rd_tag == rs_tok[p]) begin
              rs_dat[p] = ent_q[i].data;
              rs_vld[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign rs1_data_spec  = rs_dat[0];
  assign rs1_data_valid = rs_vld[0];
  assign rs2_data_spec  = rs_dat[1];
  assign rs2_data_valid = rs_vld[1];

endmodule

// File: tb/tb_rob_retire_queue.sv
// Bench for rob_retire_queue: directed stimulus with a reference queue checked every cycle on the falling edge.
module tb_rob_retire_queue;
  localparam int DEPTH = 8;
  localparam logic [1:0] T_BR = 2'd1;
  localparam logic [1:0] T_ST = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dispatch_en;
  logic [5:0]  dispatch_rd_tag;
  logic [4:0]  dispatch_rd_reg;
  logic [31:0] dispatch_pc;
  logic [1:0]  dispatch_instr_type;
  logic        rob_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        cdb_branch, cdb_branch_taken;
  logic        rs1_reg_ren, rs2_reg_ren;
  logic [5:0]  rs1_token, rs2_token;
  logic [31:0] rs1_data_spec, rs2_data_spec;
  logic        rs1_data_valid, rs2_data_valid;
  logic [5:0]  retire_rd_tag;
  logic [4:0]  retire_rd_reg;
  logic [31:0] retire_data, retire_pc;
  logic        retire_branch, retire_branch_taken, retire_store_ready;
  logic        retire_valid, retire_spec_valid, retire_flush;
  logic        retire_store_executed;

  rob_retire_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_en(dispatch_en), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rd_reg(dispatch_rd_reg), .dispatch_pc(dispatch_pc),
    .dispatch_instr_type(dispatch_instr_type), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
    .rs1_reg_ren(rs1_reg_ren), .rs1_token(rs1_token),
    .rs1_data_spec(rs1_data_spec), .rs1_data_valid(rs1_data_valid),
    .rs2_reg_ren(rs2_reg_ren), .rs2_token(rs2_token),
    .rs2_data_spec(rs2_data_spec), .rs2_data_valid(rs2_data_valid),
    .retire_rd_tag(retire_rd_tag), .retire_rd_reg(retire_rd_reg),
    .retire_data(retire_data), .retire_pc(retire_pc),
    .retire_branch(retire_branch), .retire_branch_taken(retire_branch_taken),
    .retire_store_ready(retire_store_ready), .retire_valid(retire_valid),
    .retire_spec_valid(retire_spec_valid), .retire_flush(retire_flush),
    .retire_store_executed(retire_store_executed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  ty;
    logic [31:0] data;
    logic        done;
    logic        taken;
  } exp_t;

  exp_t sb[$];
  logic m_full, m_pop, m_flush;
  logic [1:0] m_ty;

  // Reference queue: compare the head, then apply this cycle's retire/flush, dispatch and CDB.
  always @(negedge clk) begin
    if (rst_n) begin
      m_full  = (sb.size() == DEPTH);
      m_pop   = 1'b0;
      m_flush = 1'b0;
      check_eq("full", rob_full, m_full);
      if (sb.size() == 0) begin
        check_eq("ret_vld", retire_valid, 0);
      end else begin
        check_eq("ret_vld", retire_valid, 1);
        check_eq("spec_vld", retire_spec_valid, sb[0].done);
        if (sb[0].done && (sb[0].ty != T_ST || retire_store_executed)) begin
          m_pop   = 1'b1;
          m_flush = (sb[0].ty == T_BR) && sb[0].taken;
          check_eq("ret_tag", retire_rd_tag, sb[0].tag);
          check_eq("ret_reg", retire_rd_reg, sb[0].rd);
          check_eq("ret_pc", retire_pc, sb[0].pc);
          check_eq("ret_data", retire_data, sb[0].data);
          check_eq("ret_br", retire_branch, sb[0].ty == T_BR);
          check_eq("ret_st", retire_store_ready, sb[0].ty == T_ST);
          void'(sb.pop_front());
        end
      end
      check_eq("flush", retire_flush, m_flush);
      if (m_flush) sb.delete();
      if (dispatch_en && !m_full && !m_flush) begin
        m_ty = (dispatch_instr_type == 2'd3) ? 2'd0 : dispatch_instr_type;
        sb.push_back('{dispatch_rd_tag, dispatch_rd_reg, dispatch_pc, m_ty, 32'd0, 1'b0, 1'b0});
      end
      if (cdb_valid && !m_flush) begin
        foreach (sb[i]) begin
          if (sb[i].tag == cdb_tag) begin
            sb[i].data  = cdb_result;
            sb[i].done  = 1'b1;
            sb[i].taken = cdb_branch & cdb_branch_taken;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic en, input logic [5:0] tag, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [1:0] ty);
    dispatch_en = en; dispatch_rd_tag = tag; dispatch_rd_reg = rd;
    dispatch_pc = pc; dispatch_instr_type = ty;
  endtask

  task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] res,
                     input logic br, input logic tk);
    cdb_valid = v; cdb_tag = tag; cdb_result = res;
    cdb_branch = br; cdb_branch_taken = tk;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_full"}, rob_full, 0);
    check_eq({tag, "_vld"}, retire_valid, 0);
    check_eq({tag, "_spec"}, retire_spec_valid, 0);
    check_eq({tag, "_tag"}, retire_rd_tag, 0);
    check_eq({tag, "_data"}, retire_data, 0);
    check_eq({tag, "_pc"}, retire_pc, 0);
    check_eq({tag, "_flush"}, retire_flush, 0);
    check_eq({tag, "_st"}, retire_store_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    disp(0, 0, 0, 0, 0);
    cdb(0, 0, 0, 0, 0);
    rs1_reg_ren = 0; rs1_token = 0; rs2_reg_ren = 0; rs2_token = 0;
    retire_store_executed = 0;
    #12;
    check_idle_outputs("rst");
    rst_n = 1'b1;
    cyc();

    // In-order retire with out-of-order completion
    disp(1, 5, 1, 32'h100, 0); cyc();
    disp(1, 6, 2, 32'h104, 0); cyc();
    disp(1, 7, 3, 32'h108, 3); cyc();
    disp(0, 0, 0, 0, 0); cdb(1, 6, 32'hAA, 0, 0); cyc();
    cdb(1, 7, 32'h77, 0, 0);
    @(negedge clk);
    check_eq("t1_wait_vld", retire_valid, 1);
    check_eq("t1_wait_spec", retire_spec_valid, 0);
    check_eq("t1_wait_tag", retire_rd_tag, 5);
    cyc();
    cdb(1, 5, 32'h55, 0, 0); cyc();
    cdb(0, 0, 0, 0, 0);
    @(negedge clk); check_eq("t1_r5", retire_rd_tag, 5); cyc();
    @(negedge clk); check_eq("t1_r6_data", retire_data, 32'hAA); cyc();
    @(negedge clk); check_eq("t1_r7_tag", retire_rd_tag, 7); check_eq("t1_r7_br", retire_branch, 0); cyc();
    @(negedge clk); check_eq("t1_empty", retire_valid, 0); cyc();

    // Fill to full, over-dispatch ignored, full drops the cycle after a pop
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, 6'(10 + i), 5'(i), 32'h200 + 32'(4 * i), 0);
      if (i == DEPTH - 1) begin
        @(negedge clk); check_eq("t2_not_full", rob_full, 0);
      end
      cyc();
    end
    disp(1, 20, 9, 32'h2FF, 0);
    @(negedge clk); check_eq("t2_full", rob_full, 1);
    cyc();
    disp(0, 0, 0, 0, 0);
    cdb(1, 10, 32'hC010, 0, 0); cyc();
    cdb(1, 11, 32'hC011, 0, 0);
    @(negedge clk); check_eq("t2_full_pop", rob_full, 1); cyc();
    cdb(1, 12, 32'hC012, 0, 0);
    @(negedge clk); check_eq("t2_freed", rob_full, 0); cyc();
    for (int i = 13; i < 18; i++) begin
      cdb(1, 6'(i), 32'hC000 + 32'(i), 0, 0); cyc();
    end
    cdb(0, 0, 0, 0, 0);
    repeat (3) cyc();
    @(negedge clk); check_eq("t2_drained", retire_valid, 0); cyc();

    // Operand lookup: miss, CDB forward, stored value, disabled port
    disp(1, 9, 4, 32'h300, 0); cyc();
    disp(0, 0, 0, 0, 0);
    rs1_reg_ren = 1; rs1_token = 9;
    @(negedge clk);
    check_eq("t3_miss_vld", rs1_data_valid, 0);
    check_eq("t3_miss_dat", rs1_data_spec, 0);
    cyc();
    cdb(1, 9, 32'h1234, 0, 0); rs2_reg_ren = 1; rs2_token = 4;
    @(negedge clk);
    check_eq("t3_fwd_vld", rs1_data_valid, 1);
    check_eq("t3_fwd_dat", rs1_data_spec, 32'h1234);
    check_eq("t3_rs2_miss", rs2_data_valid, 0);
    cyc();
    cdb(0, 0, 0, 0, 0); rs2_reg_ren = 0; rs2_token = 9;
    @(negedge clk);
    check_eq("t3_ent_vld", rs1_data_valid, 1);
    check_eq("t3_ent_dat", rs1_data_spec, 32'h1234);
    check_eq("t3_ren0_vld", rs2_data_valid, 0);
    check_eq("t3_ren0_dat", rs2_data_spec, 0);
    cyc();
    rs1_reg_ren = 0;
    @(negedge clk); check_eq("t3_off", rs1_data_valid, 0); cyc();

    // Store waits at head for the memory handshake
    disp(1, 12, 0, 32'h400, 2); cyc();
    disp(0, 0, 0, 0, 0); retire_store_executed = 1;
    @(negedge clk); check_eq("t4_early", retire_store_ready, 0); cyc();
    retire_store_executed = 0; cdb(1, 12, 32'hBEEF, 0, 0); cyc();
    cdb(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check_eq("t4_hold", retire_store_ready, 1); cyc();
    end
    retire_store_executed = 1;
    @(negedge clk); check_eq("t4_go", retire_store_ready, 1); cyc();
    retire_store_executed = 0;
    @(negedge clk);
    check_eq("t4_done_st", retire_store_ready, 0);
    check_eq("t4_done_vld", retire_valid, 0);
    cyc();

    // Not-taken branch retires quietly, taken branch flushes younger work
    disp(1, 2, 0, 32'h500, 1); cyc();
    disp(1, 3, 0, 32'h600, 1); cyc();
    disp(1, 40, 5, 32'h604, 0); cyc();
    disp(1, 41, 6, 32'h608, 0); cyc();
    disp(0, 0, 0, 0, 0); cdb(1, 2, 0, 1, 0); cyc();
    cdb(1, 3, 0, 1, 1);
    @(negedge clk); check_eq("t5_nt_flush", retire_flush, 0); cyc();
    cdb(0, 0, 0, 0, 0); disp(1, 42, 7, 32'h700, 0);
    @(negedge clk);
    check_eq("t5_flush", retire_flush, 1);
    check_eq("t5_br", retire_branch, 1);
    check_eq("t5_taken", retire_branch_taken, 1);
    check_eq("t5_pc", retire_pc, 32'h600);
    cyc();
    disp(0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t5_after_flush", retire_flush, 0);
    check_eq("t5_after_vld", retire_valid, 0);
    check_eq("t5_after_full", rob_full, 0);
    cyc();
    cdb(1, 42, 32'h99, 0, 0); cyc();
    cdb(0, 0, 0, 0, 0);
    @(negedge clk); check_eq("t5_drop", retire_valid, 0); cyc();

    // Pointer wrap, then asynchronous reset mid-stream
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, 6'(20 + i), 5'(i), 32'h800 + 32'(i), 0); cyc();
    end
    disp(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cdb(1, 6'(20 + i), 32'hD000 + 32'(i), 0, 0); cyc();
    end
    cdb(0, 0, 0, 0, 0);
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      disp(1, 6'(30 + i), 5'(i), 32'h900 + 32'(i), 0); cyc();
    end
    disp(0, 0, 0, 0, 0); cdb(1, 30, 32'hE030, 0, 0); cyc();
    cdb(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rel_vld", retire_valid, 0);
    check_eq("t6_rel_full", rob_full, 0);
    cyc();
    disp(1, 50, 1, 32'hA00, 0); cyc();
    disp(0, 0, 0, 0, 0); cdb(1, 50, 32'h5050, 0, 0); cyc();
    cdb(0, 0, 0, 0, 0);
    repeat (3) cyc();
    @(negedge clk); check_eq("t6_final", retire_valid, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rob_retire_queue.md
Name: rob_retire_queue

Overview:
- Reorder buffer on the ROB side of the dispatch-to-ROB, rs-status and retire interfaces.
- Accepts in-order entries from the dispatcher and captures results from the CDB.
- Answers the dispatcher's speculative rs1/rs2 operand lookups.
- Retires the head entry in program order on the retire bus, including store handshakes and branch-mispredict flush.

Parameters:
DEPTH, 8, number of ROB entries (power of two, 2..32)
PTR_W, $clog2(DEPTH), head/tail pointer width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
dispatch_en  input  1  dispatcher writes a new entry this cycle
dispatch_rd_tag  input  6  tag assigned by TAG FIFO
dispatch_rd_reg  input  5  architectural destination register
dispatch_pc  input  32  instruction PC / branch jump address
dispatch_instr_type  input  2  0 NON_VALID_RD_TAG, 1 BRANCH, 2 STORE, 3 reserved (treated as 0)
rob_full  output  1  no free entry; dispatcher must hold
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  6  broadcast tag
cdb_result  input  32  broadcast result
cdb_branch  input  1  broadcast is a branch
cdb_branch_taken  input  1  branch resolved taken
rs1_reg_ren  input  1  rs1 lookup enable
rs1_token  input  6  rs1 producer tag from RST
rs1_data_spec  output  32  speculative rs1 value
rs1_data_valid  output  1  rs1 value present in ROB/CDB
rs2_reg_ren, rs2_token, rs2_data_spec, rs2_data_valid  as rs1
retire_rd_tag  output  6  head tag
retire_rd_reg  output  5  head destination register
retire_data  output  32  head result
retire_pc  output  32  head PC
retire_branch  output  1  head is BRANCH
retire_branch_taken  output  1  head branch taken (mispredict)
retire_store_ready  output  1  head is a completed STORE awaiting memory
retire_valid  output  1  head entry occupied
retire_spec_valid  output  1  head completed; retire fields valid
retire_flush  output  1  mispredict flush this cycle
retire_store_executed  input  1  memory has performed head store

Behaviour:
- Entry fields: rd_reg, rd_tag, pc, inst_type, spec_data, spec_valid, branch_taken, valid.
- Reset (async, rst_n low): all entries invalid; head = tail = 0; count = 0; every output 0; rob_full 0.
- Occupancy:
  - count range 0..DEPTH (PTR_W+1 bits); rob_full = (count == DEPTH), registered-state derived.
  - Pointers wrap modulo DEPTH.
- Push: dispatch_en && !rob_full writes entry[tail] with valid=1, spec_valid=0, branch_taken=0; tail++.
  - dispatch_en while full: ignored, no state change.
  - A pop in the same cycle does not free a slot for that cycle's push.
- CDB capture: on cdb_valid, every valid entry with rd_tag == cdb_tag takes spec_data = cdb_result, spec_valid = 1, branch_taken = cdb_branch & cdb_branch_taken.
  - Also applies to the entry being pushed in the same cycle if its tag matches.
  - Update visible on the following cycle.
- Lookup (combinational), per rs port:
  - If ren=0: data_valid=0, data_spec=0.
  - Else, if cdb_valid && cdb_tag == token: forward cdb_result, valid=1.
  - Else, if a valid entry with rd_tag == token has spec_valid: return its spec_data, valid=1.
  - Otherwise valid=0, data 0.
  - Tags are unique among live entries.
- Retire outputs: combinational from entry[head].
  - retire_valid = head.valid.
  - retire_spec_valid = head.valid & head.spec_valid.
  - retire_store_ready = retire_spec_valid & (type == STORE).
  - retire_branch = retire_valid & (type == BRANCH).
  - Data fields = head fields; zero when !retire_valid.
- Pop conditions: retire_spec_valid && (type != STORE || retire_store_executed).
  - On pop: head.valid cleared, head++, count--.
  - Store waits indefinitely at head for retire_store_executed; retire_store_executed while not store_ready is ignored.
- Flush: retire_flush = pop && type == BRANCH && head.branch_taken (combinational, one cycle).
  - Next edge: all entries invalid, head = tail = count = 0.
  - A push in the flush cycle is dropped.
  - CDB in the flush cycle has no lasting effect.
- Simultaneous push+pop (not full, no flush): count unchanged, both pointers advance.
- At most one retire per cycle.

Test Plan:
- Reset, then push 3 entries (tags 5,6,7, type 0), CDB tag 6 result 0xAA -> retire_valid=1 with spec_valid=0 until tag 5 completes; then retires 5,6(0xAA),7 on consecutive cycles; count returns 0.
- Push DEPTH=8 entries -> rob_full=1 on cycle after 8th push; 9th dispatch_en ignored; one pop -> rob_full=0 next cycle.
- rs1_token=9, ren=1, entry tag 9 spec_valid=0, cdb_valid tag 9 result 0x1234 same cycle -> rs1_data_valid=1, rs1_data_spec=0x1234; next cycle from entry, same value; ren=0 -> valid=0.
- STORE at head completed via CDB -> retire_store_ready=1, entry held 5 cycles; retire_store_executed=1 -> pop that edge, store_ready=0 next cycle.
- BRANCH tag 3 head, CDB branch_taken=1, 2 younger entries, dispatch_en in flush cycle -> retire_flush=1 one cycle, then retire_valid=0, rob_full=0, count=0, dispatched entry absent.
- Fill to wrap (push 8, pop 8, push 3) with rst_n asserted mid-stream -> all outputs 0 immediately, queue empty after release.
